// File: rtl/int_to_float.sv
// rtl/int_to_float.sv - 32-bit signed integer to IEEE-754 single, round to nearest even
module int_to_float (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        GET_A,
        CONVERT,
        NORMALISE,
        ROUND,
        PACK,
        PUT_Z
    } state_t;

    state_t      state;
    logic [31:0] a_reg;
    logic [31:0] value;
    logic [7:0]  exp;
    logic        sign;
    logic [23:0] mant;

    logic        guard_bit;
    logic        round_bit;
    logic        sticky_bit;
    logic        round_up;
    logic [24:0] mant_inc;

    assign guard_bit  = value[7];
    assign round_bit  = value[6];
    assign sticky_bit = |value[5:0];
    assign round_up   = guard_bit && (round_bit || sticky_bit || value[8]);
    assign mant_inc   = {1'b0, value[31:8]} + {24'd0, round_up};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= GET_A;
            input_a_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= 32'd0;
            a_reg        <= 32'd0;
            value        <= 32'd0;
            exp          <= 8'd0;
            sign         <= 1'b0;
            mant         <= 24'd0;
        end else begin
            case (state)
                GET_A: begin
                    if (!input_a_ack)
                        input_a_ack <= 1'b1;
                    if (input_a_stb && input_a_ack) begin
                        a_reg       <= input_a;
                        input_a_ack <= 1'b0;
                        state       <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (a_reg == 32'd0) begin
                        output_z <= 32'd0;
                        state    <= PUT_Z;
                    end else begin
                        sign  <= a_reg[31];
                        // -2^31 negates to itself, which is already the correct magnitude
                        value <= a_reg[31] ? (~a_reg + 32'd1) : a_reg;
                        exp   <= 8'd31;
                        state <= NORMALISE;
                    end
                end
                NORMALISE: begin
                    if (!value[31]) begin
                        value <= {value[30:0], 1'b0};
                        exp   <= exp - 8'd1;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (mant_inc[24]) begin
                        mant <= 24'h800000;
                        exp  <= exp + 8'd1;
                    end else begin
                        mant <= mant_inc[23:0];
                    end
                    state <= PACK;
                end
                PACK: begin
                    // strobe raised here so it appears on the same edge as the result
                    output_z     <= {sign, exp + 8'd127, mant[22:0]};
                    output_z_stb <= 1'b1;
                    state        <= PUT_Z;
                end
                PUT_Z: begin
                    if (output_z_stb && output_z_ack) begin
                        output_z_stb <= 1'b0;
                        input_a_ack  <= 1'b1;
                        state        <= GET_A;
                    end else begin
                        output_z_stb <= 1'b1;
                    end
                end
                default: state <= GET_A;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_float.sv
// tb/tb_int_to_float.sv - randomized self-checking bench for int_to_float
module tb_int_to_float;

    logic        clk;
    logic        rst;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int tests_run;
    int tests_failed;

    int_to_float dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // Reference: exact integer magnitude, rounded by remainder comparison.
    function automatic logic [31:0] ref_float(input logic [31:0] a);
        longint v, q, rem, half;
        int     p, sh;
        logic   s;
        logic [31:0] r;
        if (a == 32'd0) return 32'd0;
        v = longint'($signed(a));
        s = (v < 0);
        if (s) v = -v;
        p = 0;
        for (int i = 0; i < 32; i++)
            if (v >= (64'sd1 <<< i)) p = i;
        if (p <= 23) begin
            q = v <<< (23 - p);
        end else begin
            sh   = p - 23;
            q    = v >>> sh;
            rem  = v - (q <<< sh);
            half = 64'sd1 <<< (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'sd1 <<< 24)) begin
                q = q >>> 1;
                p = p + 1;
            end
        end
        r = {s, 8'(p + 127), q[22:0]};
        return r;
    endfunction

    function automatic int ref_latency(input logic [31:0] a);
        longint v;
        int     p;
        if (a == 32'd0) return 2;
        v = longint'($signed(a));
        if (v < 0) v = -v;
        p = 0;
        for (int i = 0; i < 32; i++)
            if (v >= (64'sd1 <<< i)) p = i;
        return (31 - p) + 4;
    endfunction

    // Integer value of a float known to hold an exact integer.
    function automatic longint float_to_int(input logic [31:0] f);
        longint m, v;
        int     e;
        if (f[30:0] == 31'd0) return 0;
        e = int'(f[30:23]) - 127;
        m = longint'({1'b1, f[22:0]});
        v = (e >= 23) ? (m <<< (e - 23)) : (m >>> (23 - e));
        return f[31] ? -v : v;
    endfunction

    task automatic convert(input logic [31:0] a, input int hold, output logic [31:0] z);
        int t, lat;
        logic [31:0] held;
        t = 0;
        while (!input_a_ack && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        if (!input_a_ack) begin
            chk("accept_timeout", {31'd0, input_a_ack}, 32'd1);
            z = 32'd0;
            return;
        end
        input_a     = a;
        input_a_stb = 1'b1;
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        input_a     = $urandom;
        lat = 0;
        while (!output_z_stb && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (output_z_stb && input_a_ack) chk("ack_stb_overlap", 32'd1, 32'd0);
        end
        chk("latency", lat, ref_latency(a));
        z    = output_z;
        held = output_z;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_z", output_z, held);
            chk("bp_stb", {31'd0, output_z_stb}, 32'd1);
            chk("bp_in_ack", {31'd0, input_a_ack}, 32'd0);
        end
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        output_z_ack = 1'b0;
        chk("xfer_stb", {31'd0, output_z_stb}, 32'd0);
        chk("xfer_in_ack", {31'd0, input_a_ack}, 32'd1);
    endtask

    logic [31:0] z, z15, z7, a;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        input_a      = 32'd0;
        input_a_stb  = 1'b0;
        output_z_ack = 1'b0;
        #12;
        chk("rst_in_ack", {31'd0, input_a_ack}, 32'd0);
        chk("rst_stb", {31'd0, output_z_stb}, 32'd0);
        chk("rst_z", output_z, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ack", {31'd0, input_a_ack}, 32'd1);

        convert(32'd15, 0, z);          chk("c15", z, 32'h41700000);
        convert(32'd7, 0, z);           chk("c7", z, 32'h40E00000);
        convert(32'hFFFFFFFF, 0, z);    chk("cm1", z, 32'hBF800000);
        convert(32'd0, 0, z);           chk("c0", z, 32'h00000000);
        convert(32'h80000000, 0, z);    chk("cmin", z, 32'hCF000000);
        convert(32'h7FFFFFFF, 0, z);    chk("cmax", z, 32'h4F000000);
        convert(32'd16777217, 0, z);    chk("tie_even", z, 32'h4B800000);
        convert(32'd16777219, 0, z);    chk("tie_up", z, 32'h4B800002);
        convert(32'd1, 0, z);           chk("c1", z, 32'h3F800000);
        convert(32'd15, 5, z);          chk("bp15", z, 32'h41700000);

        // reset during NORMALISE of input 1
        input_a     = 32'd1;
        input_a_stb = 1'b1;
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_stb", {31'd0, output_z_stb}, 32'd0);
        chk("mid_rst_z", output_z, 32'd0);
        chk("mid_rst_ack", {31'd0, input_a_ack}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        convert(32'd7, 0, z);           chk("after_rst7", z, 32'h40E00000);

        // converter feeding an adder operand pair
        convert(32'd15, 0, z15);
        convert(32'd7, 0, z7);
        chk("adder_sum", ref_float(32'(float_to_int(z15) + float_to_int(z7))), 32'h41B00000);

        for (int i = 0; i < 200; i++) begin
            a = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) a = ~a + 32'd1;
            if (i == 0) a = 32'h00FFFFFF;
            convert(a, $urandom_range(0, 2), z);
            chk($sformatf("rand_%0d_%08h", i, a), z, ref_float(a));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
